// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose: MEM-stage controller between the EX stage and the data cache.
// A load/store in EX is latched, issued to the Dcache through a small FSM
// (IDLE -> REQ -> [WAIT_R] -> DONE), and the pipeline is held until the
// access finishes. Non-memory instructions flow straight through to the
// registered writeback outputs.
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to enable alignment checks.
//   Defined:   a misaligned half/word access issues no request, does not
//              stall, writes back with we=0 and pulses mem_misalign_o.
//   Undefined: low address bits are ignored (half uses addr[1], word is
//              forced aligned) and mem_misalign_o is tied low.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_*                    EX-stage instruction fields (type, rw, width,
//                           load extension, store data, address, rd, we)
//   dcache_req_o/we_o/addr_o/wstrb_o/wdata_o   request to the Dcache
//   dcache_ready_i          Dcache accepts the request this cycle
//   dcache_rvalid_i/rdata_i read data return
//   fc_Dcache_stall_flag_o  combinational pipeline hold
//   mem_reg_we_o/waddr_o/wdata_o   registered writeback to WB
//   mem_misalign_o          registered one-cycle misalignment pulse
//   fsm_state               debug view of the FSM (0 IDLE, 1 REQ,
//                           2 WAIT_R, 3 DONE)
//
// Handshake: a request transfers on a rising edge where dcache_req_o=1 and
// dcache_ready_i=1; request fields stay stable while dcache_req_o=1 and
// ready is low. Read data is taken on the first edge with dcache_rvalid_i=1
// while in WAIT_R (at the earliest one cycle after acceptance); rvalid in
// any other state is ignored.
// -----------------------------------------------------------------------------
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mtype_i,
    input  logic        ex_mem_rw_i,
    input  logic [1:0]  ex_mem_width_i,
    input  logic        ex_mem_rdtype_i,
    input  logic [31:0] ex_mem_wr_data_i,
    input  logic [31:0] ex_alu_result_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic        ex_reg_we_i,
    output logic        dcache_req_o,
    output logic        dcache_we_o,
    output logic [31:0] dcache_addr_o,
    output logic [3:0]  dcache_wstrb_o,
    output logic [31:0] dcache_wdata_o,
    input  logic        dcache_ready_i,
    input  logic        dcache_rvalid_i,
    input  logic [31:0] dcache_rdata_i,
    output logic        fc_Dcache_stall_flag_o,
    output logic        mem_reg_we_o,
    output logic [4:0]  mem_reg_waddr_o,
    output logic [31:0] mem_reg_wdata_o,
    output logic        mem_misalign_o,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state, state_nx;

    // Latched copy of the memory instruction
    logic        lat_rw;
    logic [1:0]  lat_width;
    logic        lat_rdtype;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic [4:0]  lat_waddr;
    logic        lat_we;
    logic [31:0] load_data;

    logic        misaligned;
    logic        start;
    logic        stall;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

`ifdef MEM_MISALIGN_CHECK_EN
    // Width 2'b11 is treated as a word.
    assign misaligned = ex_mtype_i &&
                        (((ex_mem_width_i == 2'b01) && ex_alu_result_i[0]) ||
                         (ex_mem_width_i[1] && (ex_alu_result_i[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned access never leaves IDLE, so it never stalls.
    assign start     = (state == IDLE) && ex_mtype_i && !misaligned;
    assign stall     = start || (state == REQ) || (state == WAIT_R);
    assign fsm_state = state;

    assign fc_Dcache_stall_flag_o = stall;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = REQ;
            REQ:     if (dcache_ready_i) state_nx = lat_rw ? DONE : WAIT_R;
            WAIT_R:  if (dcache_rvalid_i) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- Request path (driven only from latched fields) ----------------
    assign dcache_req_o  = (state == REQ);
    assign dcache_we_o   = lat_rw;
    assign dcache_addr_o = {lat_addr[31:2], 2'b00};

    always_comb begin
        dcache_wstrb_o = 4'b0000;
        dcache_wdata_o = lat_data;
        case (lat_width)
            2'b00: begin
                dcache_wdata_o = {4{lat_data[7:0]}};
                dcache_wstrb_o = 4'b0001 << lat_addr[1:0];
            end
            2'b01: begin
                dcache_wdata_o = {2{lat_data[15:0]}};
                dcache_wstrb_o = 4'b0011 << {lat_addr[1], 1'b0};
            end
            default: begin
                dcache_wdata_o = lat_data;
                dcache_wstrb_o = 4'b1111;
            end
        endcase
        if (!lat_rw) begin
            dcache_wstrb_o = 4'b0000;
        end
    end

    // ---------------- Load lane select and extension ----------------
    always_comb begin
        rd_byte = 8'h00;
        case (lat_addr[1:0])
            2'b00:   rd_byte = dcache_rdata_i[7:0];
            2'b01:   rd_byte = dcache_rdata_i[15:8];
            2'b10:   rd_byte = dcache_rdata_i[23:16];
            default: rd_byte = dcache_rdata_i[31:24];
        endcase
        rd_half = lat_addr[1] ? dcache_rdata_i[31:16] : dcache_rdata_i[15:0];
        case (lat_width)
            2'b00:   rd_ext = lat_rdtype ? {24'h000000, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = lat_rdtype ? {16'h0000, rd_half}   : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = dcache_rdata_i;
        endcase
    end

    // ---------------- Instruction latch and load capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_rw     <= 1'b0;
            lat_width  <= 2'b00;
            lat_rdtype <= 1'b0;
            lat_addr   <= 32'h0;
            lat_data   <= 32'h0;
            lat_waddr  <= 5'd0;
            lat_we     <= 1'b0;
            load_data  <= 32'h0;
        end else begin
            if (start) begin
                lat_rw     <= ex_mem_rw_i;
                lat_width  <= ex_mem_width_i;
                lat_rdtype <= ex_mem_rdtype_i;
                lat_addr   <= ex_alu_result_i;
                lat_data   <= ex_mem_wr_data_i;
                lat_waddr  <= ex_reg_waddr_i;
                lat_we     <= ex_reg_we_i;
            end
            if ((state == WAIT_R) && dcache_rvalid_i) begin
                load_data <= rd_ext;
            end
        end
    end

    // ---------------- Writeback registers ----------------
    // Stall cycles insert a bubble (we=0) and hold address/data. With stall
    // low the state is either DONE (retire the memory op) or IDLE with a
    // non-memory (or rejected misaligned) instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg_we_o    <= 1'b0;
            mem_reg_waddr_o <= 5'd0;
            mem_reg_wdata_o <= 32'h0;
        end else if (stall) begin
            mem_reg_we_o <= 1'b0;
        end else if (state == DONE) begin
            if (lat_rw) begin
                mem_reg_we_o <= 1'b0;
            end else begin
                mem_reg_we_o    <= lat_we;
                mem_reg_waddr_o <= lat_waddr;
                mem_reg_wdata_o <= load_data;
            end
        end else if (misaligned) begin
            mem_reg_we_o <= 1'b0;
        end else begin
            mem_reg_we_o    <= ex_reg_we_i;
            mem_reg_waddr_o <= ex_reg_waddr_i;
            mem_reg_wdata_o <= ex_alu_result_i;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_misalign_o <= 1'b0;
        end else begin
            mem_misalign_o <= (state == IDLE) && misaligned;
        end
    end
`else
    assign mem_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed and randomized stimulus for mem_access_ctrl. A behavioural model
// computes strobes, replicated store data, load extension and the expected
// writeback triple; expected writebacks go through exp_q.
// Honours MEM_MISALIGN_CHECK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    // ---------------- Clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        ex_mtype_i;
    logic        ex_mem_rw_i;
    logic [1:0]  ex_mem_width_i;
    logic        ex_mem_rdtype_i;
    logic [31:0] ex_mem_wr_data_i;
    logic [31:0] ex_alu_result_i;
    logic [4:0]  ex_reg_waddr_i;
    logic        ex_reg_we_i;
    logic        dcache_req_o;
    logic        dcache_we_o;
    logic [31:0] dcache_addr_o;
    logic [3:0]  dcache_wstrb_o;
    logic [31:0] dcache_wdata_o;
    logic        dcache_ready_i;
    logic        dcache_rvalid_i;
    logic [31:0] dcache_rdata_i;
    logic        fc_Dcache_stall_flag_o;
    logic        mem_reg_we_o;
    logic [4:0]  mem_reg_waddr_o;
    logic [31:0] mem_reg_wdata_o;
    logic        mem_misalign_o;
    logic [1:0]  fsm_state;

    mem_access_ctrl dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .ex_mtype_i             (ex_mtype_i),
        .ex_mem_rw_i            (ex_mem_rw_i),
        .ex_mem_width_i         (ex_mem_width_i),
        .ex_mem_rdtype_i        (ex_mem_rdtype_i),
        .ex_mem_wr_data_i       (ex_mem_wr_data_i),
        .ex_alu_result_i        (ex_alu_result_i),
        .ex_reg_waddr_i         (ex_reg_waddr_i),
        .ex_reg_we_i            (ex_reg_we_i),
        .dcache_req_o           (dcache_req_o),
        .dcache_we_o            (dcache_we_o),
        .dcache_addr_o          (dcache_addr_o),
        .dcache_wstrb_o         (dcache_wstrb_o),
        .dcache_wdata_o         (dcache_wdata_o),
        .dcache_ready_i         (dcache_ready_i),
        .dcache_rvalid_i        (dcache_rvalid_i),
        .dcache_rdata_i         (dcache_rdata_i),
        .fc_Dcache_stall_flag_o (fc_Dcache_stall_flag_o),
        .mem_reg_we_o           (mem_reg_we_o),
        .mem_reg_waddr_o        (mem_reg_waddr_o),
        .mem_reg_wdata_o        (mem_reg_wdata_o),
        .mem_misalign_o         (mem_misalign_o),
        .fsm_state              (fsm_state)
    );

    // ---------------- Scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    // {misalign, we, waddr, wdata}
    logic [38:0] exp_q[$];
    logic        exp_mis   = 1'b0;
    logic        exp_we    = 1'b0;
    logic [4:0]  exp_waddr = 5'd0;
    logic [31:0] exp_wdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    function automatic logic is_mis(input logic [1:0] width, input logic [31:0] addr);
`ifdef MEM_MISALIGN_CHECK_EN
        if (width == 2'b01) return addr[0];
        if (width[1])       return (addr[1:0] != 2'b00);
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_strb(input logic rw, input logic [1:0] width,
                                            input logic [31:0] addr);
        logic [3:0] s;
        if (!rw) return 4'b0000;
        if (width == 2'b00)      s = 4'b0001 << addr[1:0];
        else if (width == 2'b01) s = 4'b0011 << (2 * int'(addr[1]));
        else                     s = 4'b1111;
        return s;
    endfunction

    function automatic logic [31:0] exp_store(input logic [1:0] width, input logic [31:0] d);
        logic [31:0] b, h;
        b = d & 32'hFF;
        h = d & 32'hFFFF;
        if (width == 2'b00) return b * 32'h01010101;
        if (width == 2'b01) return h * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] width, input logic rdtype,
                                             input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        int nbits;
        if (width == 2'b00) begin
            v = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
            nbits = 8;
        end else if (width == 2'b01) begin
            v = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
            nbits = 16;
        end else begin
            return rdata;
        end
        if (!rdtype && v[nbits-1]) v = v | (32'hFFFFFFFF << nbits);
        return v;
    endfunction

    task automatic push_exp();
        exp_q.push_back({exp_mis, exp_we, exp_waddr, exp_wdata});
    endtask

    task automatic check_wb(input string tag);
        logic [38:0] e;
        e = exp_q.pop_front();
        check({tag, "_mis"},   32'(mem_misalign_o),  32'(e[38]));
        check({tag, "_we"},    32'(mem_reg_we_o),    32'(e[37]));
        check({tag, "_waddr"}, 32'(mem_reg_waddr_o), 32'(e[36:32]));
        check({tag, "_wdata"}, mem_reg_wdata_o,      e[31:0]);
    endtask

    // ---------------- Driver tasks (entered and left at a negedge) ----------------
    task automatic alu_op(input string tag, input logic [31:0] result,
                          input logic [4:0] waddr, input logic we);
        ex_mtype_i       = 1'b0;
        ex_mem_rw_i      = 1'($urandom_range(0, 1));
        ex_mem_width_i   = 2'($urandom_range(0, 3));
        ex_mem_rdtype_i  = 1'($urandom_range(0, 1));
        ex_mem_wr_data_i = $urandom;
        ex_alu_result_i  = result;
        ex_reg_waddr_i   = waddr;
        ex_reg_we_i      = we;
        #1;
        check({tag, "_stall"}, 32'(fc_Dcache_stall_flag_o), 32'd0);
        exp_mis   = 1'b0;
        exp_we    = we;
        exp_waddr = waddr;
        exp_wdata = result;
        push_exp();
        @(negedge clk);
        check_wb(tag);
    endtask

    task automatic mem_op(input string tag, input logic rw, input logic [1:0] width,
                          input logic rdtype, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] waddr, input logic we,
                          input int ready_dly, input int rvalid_dly,
                          input logic [31:0] rdata, input logic stray);
        int   stalls;
        int   req_cycles;
        int   wait_cycles;
        int   exp_stalls;
        logic accepted;
        logic mis;
        ex_mtype_i       = 1'b1;
        ex_mem_rw_i      = rw;
        ex_mem_width_i   = width;
        ex_mem_rdtype_i  = rdtype;
        ex_mem_wr_data_i = data;
        ex_alu_result_i  = addr;
        ex_reg_waddr_i   = waddr;
        ex_reg_we_i      = we;
        dcache_ready_i   = 1'b0;
        dcache_rvalid_i  = 1'b0;
        mis         = is_mis(width, addr);
        stalls      = 0;
        req_cycles  = 0;
        wait_cycles = 0;
        accepted    = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!fc_Dcache_stall_flag_o) break;
            stalls++;
            dcache_ready_i  = 1'b0;
            dcache_rvalid_i = 1'b0;
            dcache_rdata_i  = $urandom;
            if (dcache_req_o) begin
                check({tag, "_req_addr"},  dcache_addr_o, {addr[31:2], 2'b00});
                check({tag, "_req_we"},    32'(dcache_we_o), 32'(rw));
                check({tag, "_req_wstrb"}, 32'(dcache_wstrb_o), 32'(exp_strb(rw, width, addr)));
                if (rw) check({tag, "_req_wdata"}, dcache_wdata_o, exp_store(width, data));
                // rvalid while a request is pending must be ignored
                if (stray) dcache_rvalid_i = 1'b1;
                if (req_cycles == ready_dly) begin
                    dcache_ready_i = 1'b1;
                    accepted = 1'b1;
                end
                req_cycles++;
            end else if (accepted) begin
                if (wait_cycles == rvalid_dly) begin
                    dcache_rvalid_i = 1'b1;
                    dcache_rdata_i  = rdata;
                end
                wait_cycles++;
            end
            if (c > 0) begin
                // The instruction is latched; EX-side changes must not leak in.
                ex_mem_rw_i      = 1'($urandom_range(0, 1));
                ex_mem_width_i   = 2'($urandom_range(0, 3));
                ex_mem_rdtype_i  = 1'($urandom_range(0, 1));
                ex_mem_wr_data_i = $urandom;
                ex_alu_result_i  = $urandom;
                ex_reg_waddr_i   = 5'($urandom_range(0, 31));
                ex_reg_we_i      = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        exp_stalls = mis ? 0 : (1 + ready_dly + 1 + (rw ? 0 : rvalid_dly + 1));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        check({tag, "_done_req"}, 32'(dcache_req_o), 32'd0);
        dcache_ready_i  = 1'b0;
        dcache_rvalid_i = 1'b0;
        if (mis) begin
            exp_mis = 1'b1;
            exp_we  = 1'b0;
        end else if (rw) begin
            exp_mis = 1'b0;
            exp_we  = 1'b0;
        end else begin
            exp_mis   = 1'b0;
            exp_we    = we;
            exp_waddr = waddr;
            exp_wdata = exp_load(width, rdtype, addr, rdata);
        end
        push_exp();
        @(negedge clk);
        check_wb(tag);
    endtask

    // ---------------- Watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- Directed + random sequence ----------------
    initial begin
        rst_n            = 1'b0;
        ex_mtype_i       = 1'b0;
        ex_mem_rw_i      = 1'b0;
        ex_mem_width_i   = 2'b00;
        ex_mem_rdtype_i  = 1'b0;
        ex_mem_wr_data_i = 32'h0;
        ex_alu_result_i  = 32'h0;
        ex_reg_waddr_i   = 5'd0;
        ex_reg_we_i      = 1'b0;
        dcache_ready_i   = 1'b0;
        dcache_rvalid_i  = 1'b0;
        dcache_rdata_i   = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_req",   32'(dcache_req_o), 32'd0);
        check("reset_stall", 32'(fc_Dcache_stall_flag_o), 32'd0);
        check("reset_we",    32'(mem_reg_we_o), 32'd0);
        check("reset_waddr", 32'(mem_reg_waddr_o), 32'd0);
        check("reset_wdata", mem_reg_wdata_o, 32'd0);
        check("reset_mis",   32'(mem_misalign_o), 32'd0);
        check("reset_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LW, ready in the request cycle, rvalid the next cycle
        mem_op("lw_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1, 0, 0, 32'hDEADBEEF, 1'b0);
        // LB signed / LBU on the top byte lane
        mem_op("lb_103",  1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd4, 1'b1, 1, 2, 32'h80112233, 1'b1);
        mem_op("lbu_103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd5, 1'b1, 0, 1, 32'h80112233, 1'b0);
        // SH upper half with ready delayed 4 cycles and stray rvalid
        mem_op("sh_202", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 5'd6, 1'b1, 4, 0, 32'h0, 1'b1);
        // Plain ALU result
        alu_op("add_55", 32'h55, 5'd7, 1'b1);
        // Signed half load from the upper lane, width 11 as word
        mem_op("lh_202", 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 5'd8, 1'b1, 2, 0, 32'h9ABC1234, 1'b0);
        mem_op("lw11_204", 1'b0, 2'b11, 1'b0, 32'h204, 32'h0, 5'd9, 1'b1, 0, 3, 32'h13579BDF, 1'b0);
        mem_op("sb_301", 1'b1, 2'b00, 1'b0, 32'h301, 32'h123456A5, 5'd1, 1'b1, 1, 0, 32'h0, 1'b0);
        // Low-bit handling: misaligned with the check, ignored without it
        mem_op("lw_101", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd10, 1'b1, 0, 0, 32'hCAFEF00D, 1'b0);
        alu_op("after_mis", 32'h77, 5'd11, 1'b1);
        mem_op("lh_203", 1'b0, 2'b01, 1'b1, 32'h203, 32'h0, 5'd12, 1'b1, 0, 0, 32'hF00D8001, 1'b0);
        mem_op("sw_306", 1'b1, 2'b10, 1'b0, 32'h306, 32'hA5A5F0F0, 5'd13, 1'b1, 0, 0, 32'h0, 1'b0);
        alu_op("pre_rst", 32'h1234_5678, 5'd14, 1'b1);

        // Reset while waiting for read data
        ex_mtype_i      = 1'b1;
        ex_mem_rw_i     = 1'b0;
        ex_mem_width_i  = 2'b10;
        ex_alu_result_i = 32'h300;
        ex_reg_waddr_i  = 5'd15;
        ex_reg_we_i     = 1'b1;
        @(negedge clk);
        #1;
        check("rst_pre_req", 32'(dcache_req_o), 32'd1);
        dcache_ready_i = 1'b1;
        @(negedge clk);
        dcache_ready_i = 1'b0;
        #1;
        check("rst_waitr_stall", 32'(fc_Dcache_stall_flag_o), 32'd1);
        ex_mtype_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_req",   32'(dcache_req_o), 32'd0);
        check("rst_async_stall", 32'(fc_Dcache_stall_flag_o), 32'd0);
        check("rst_async_we",    32'(mem_reg_we_o), 32'd0);
        check("rst_async_waddr", 32'(mem_reg_waddr_o), 32'd0);
        check("rst_async_wdata", mem_reg_wdata_o, 32'd0);
        check("rst_async_state", 32'(fsm_state), 32'd0);
        exp_mis   = 1'b0;
        exp_we    = 1'b0;
        exp_waddr = 5'd0;
        exp_wdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        // Late rvalid after the abandoned request must be ignored in IDLE
        dcache_rvalid_i = 1'b1;
        dcache_rdata_i  = 32'hBAADF00D;
        alu_op("post_rst", 32'h0000_00AA, 5'd16, 1'b1);
        dcache_rvalid_i = 1'b0;
        mem_op("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd17, 1'b1, 1, 1, 32'h0BADCAFE, 1'b0);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                alu_op("rnd_alu", $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else begin
                mem_op("rnd_mem", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom, $urandom,
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       $urandom, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: ex_mtype_i  in  1  current EX instruction is a load/store.
REQ-004 SHALL: ex_mem_rw_i  in  1  1=store, 0=load.
REQ-005 SHALL: ex_mem_width_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-006 SHALL: ex_mem_rdtype_i  in  1  load extension: 0 sign-extend, 1 zero-extend.
REQ-007 SHALL: ex_mem_wr_data_i  in  32  store data, LSB-aligned.
REQ-008 SHALL: ex_alu_result_i  in  32  ALU result; byte address for memory ops.
REQ-009 SHALL: ex_reg_waddr_i  in  5  destination register.
REQ-010 SHALL: ex_reg_we_i  in  1  register write enable.
REQ-011 SHALL: dcache_req_o  out  1  request valid to Dcache.
REQ-012 SHALL: dcache_we_o  out  1  1=write request.
REQ-013 SHALL: dcache_addr_o  out  32  word address, bits [1:0] forced to 0.
REQ-014 SHALL: dcache_wstrb_o  out  4  byte-lane write strobes.
REQ-015 SHALL: dcache_wdata_o  out  32  lane-replicated store data.
REQ-016 SHALL: dcache_ready_i  in  1  Dcache accepts request this cycle.
REQ-017 SHALL: dcache_rvalid_i  in  1  read data valid.
REQ-018 SHALL: dcache_rdata_i  in  32  read word.
REQ-019 SHALL: fc_Dcache_stall_flag_o  out  1  combinational pipeline hold to flow control.
REQ-020 SHALL: mem_reg_we_o / mem_reg_waddr_o / mem_reg_wdata_o  out  1/5/32  registered writeback to WB.
REQ-021 SHALL: mem_misalign_o  out  1  registered one-cycle misalignment pulse (see REQ-036).

Function
REQ-022 SHALL: FSM states IDLE, REQ, WAIT_R, DONE.
REQ-023 SHALL: IDLE with ex_mtype_i=1 -> latch rw, width, rdtype, address, store data, waddr, we; go REQ.
REQ-024 SHALL: REQ drives dcache_req_o=1 with latched fields stable until dcache_ready_i=1; then store -> DONE, load -> WAIT_R.
REQ-025 SHALL: WAIT_R holds until dcache_rvalid_i=1 (earliest one cycle after acceptance), captures extended data, goes DONE; rvalid in other states is ignored.
REQ-026 SHALL: DONE ignores ex_mtype_i (same held instruction), returns to IDLE next cycle.
REQ-027 SHALL: fc_Dcache_stall_flag_o = (IDLE & ex_mtype_i) | REQ | WAIT_R; low in DONE.
REQ-028 SHALL: writeback regs update only on cycles with stall low: non-memory -> we/waddr from EX, wdata=ex_alu_result_i; DONE load -> latched we/waddr, extended data; DONE store -> we=0.
REQ-029 SHALL: stall-high cycles load mem_reg_we_o=0 (bubble), waddr/wdata hold.
REQ-030 SHALL: store strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; wdata byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-031 SHALL: load select: byte lane addr[1:0], half lane addr[1], word full; extend to 32 bits per rdtype.
REQ-032 SHALL: dcache_we_o, addr, wstrb, wdata are don't-care but held while dcache_req_o=0; wstrb=0 for loads.

Reset
REQ-033 SHALL: rst_n low, any state -> IDLE immediately; dcache_req_o, mem_reg_we_o, mem_misalign_o=0; waddr=0; wdata=0; all latches 0.
REQ-034 SHALL: reset mid-transaction abandons the request without waiting for ready/rvalid.

Configuration
REQ-035 SHALL: macro MEM_MISALIGN_CHECK_EN selects alignment checking.
REQ-036 SHALL: defined -> half with addr[0]=1 or word with addr[1:0]!=0 issues no request, no stall, writeback we=0, mem_misalign_o=1 one cycle; undefined -> low bits ignored (half uses addr[1], word forced aligned), mem_misalign_o tied 0.

Verification
REQ-037 SHALL: LW addr 0x100, ready same cycle, rvalid next with 0xDEADBEEF -> stall 3 cycles, then wdata 0xDEADBEEF, we=1.
REQ-038 SHALL: LB signed addr 0x103, rdata 0x80112233 -> wdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-039 SHALL: SH addr 0x202 data 0x0000ABCD, ready delayed 4 cycles -> req held stable, wstrb 4'b1100, wdata 0xABCDABCD, mem_reg_we_o=0.
REQ-040 SHALL: ADD result 0x55 with no memory op -> no stall, next cycle wdata 0x55, we=1.
REQ-041 SHALL: rst_n low in WAIT_R -> req=0, IDLE; with MEM_MISALIGN_CHECK_EN, LW addr 0x101 -> no req, mem_misalign_o pulse, we=0.
